// File: rtl/modn_counter_pkg.sv
// Shared types and helpers for the modulo-N digit counter and its BCD converter.
package modn_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    // Packed BCD of a non-negative constant, up to 8 digits, for elaboration-time use.
    function automatic logic [31:0] bcd_of_const(input int value);
        logic [31:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Returns {ripple, digit}: ripple set when the digit wraps 9 -> 0.
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d);
        return (d == 4'd9) ? 5'b1_0000 : {1'b0, d + 4'd1};
    endfunction

    // Returns {borrow, digit}: borrow set when the digit wraps 0 -> 9.
    function automatic logic [4:0] bcd_digit_dec(input logic [3:0] d);
        return (d == 4'd0) ? 5'b1_1001 : {1'b0, d - 4'd1};
    endfunction

    // Double-dabble correction applied to each digit before a shift.
    function automatic logic [3:0] bcd_digit_adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift per cycle, WIDTH cycles per value.
module bin2bcd_seq #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [WIDTH-1:0]    din,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result
);
    import modn_counter_pkg::*;

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] bin_sr;
    logic [BW-1:0]    bcd_sr;
    logic [BW-1:0]    bcd_adj;
    logic [CW-1:0]    cyc_left;

    // Add-3 correction of every digit ahead of the next shift.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj[4*i +: 4] = bcd_digit_adj(bcd_sr[4*i +: 4]);
        end
    end

    // done marks the cycle whose edge performs the final shift; result is complete after it.
    assign done   = busy && (cyc_left == CW'(1));
    assign result = bcd_sr;

    // Snapshot on start, then shift-add-3 with a down-counted cycle budget; abort drops any run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            cyc_left <= '0;
            bin_sr   <= '0;
            bcd_sr   <= '0;
        end else if (abort) begin
            busy     <= 1'b0;
            cyc_left <= '0;
        end else if (start && !busy) begin
            bin_sr   <= din;
            bcd_sr   <= '0;
            cyc_left <= CW'(WIDTH);
            busy     <= 1'b1;
        end else if (busy) begin
            {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
            cyc_left         <= cyc_left - CW'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/modn_counter.sv
// Modulo-N up/down digit counter with carry for cascading, load/clear/lap and a BCD shadow.
//
// state | meaning
// IDLE  | count_bcd tracks count incrementally on every tick
// CONV  | converter snapshotting (first cycle) or shifting the loaded count
// DONE  | conversion result ready; commit it unless a tick made it stale
module modn_counter #(
    parameter int WIDTH   = 7,
    parameter int MODULUS = 100,
    parameter int DIGITS  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                dir,
    input  logic                clr,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_val,
    input  logic                lap,
    output logic [WIDTH-1:0]    count,
    output logic [4*DIGITS-1:0] count_bcd,
    output logic                bcd_valid,
    output logic                carry,
    output logic [WIDTH-1:0]    lap_val,
    output logic                load_err
);
    import modn_counter_pkg::*;

    localparam int                BW           = 4 * DIGITS;
    localparam logic [WIDTH-1:0]  CNT_MAX      = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]    MOD_EXT      = (WIDTH + 1)'(MODULUS);
    localparam logic [31:0]       BCD_MAX_FULL = bcd_of_const(MODULUS - 1);
    localparam logic [BW-1:0]     BCD_MAX      = BCD_MAX_FULL[BW-1:0];

    if (MODULUS < 2) begin : g_chk_modulus
        $error("modn_counter: MODULUS must be at least 2");
    end
    if ((longint'(1) << WIDTH) < longint'(MODULUS)) begin : g_chk_width
        $error("modn_counter: WIDTH too small for MODULUS");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_chk_digits_range
        $error("modn_counter: DIGITS must be 1..8");
    end
    if (pow10(DIGITS) < longint'(MODULUS)) begin : g_chk_digits
        $error("modn_counter: DIGITS too small for MODULUS");
    end

    conv_state_t      state, state_nxt;
    logic             dirty;
    logic             load_ok, load_acc, tick_acc, wrap;
    logic             at_top, at_zero;
    logic [WIDTH-1:0] count_nxt;
    logic [BW-1:0]    bcd_step;
    logic             conv_start, conv_abort, conv_busy, conv_done;
    logic [BW-1:0]    conv_result;
    logic             write_bcd;

    assign load_ok  = load && ({1'b0, load_val} < MOD_EXT);
    assign load_acc = !clr && load_ok;
    assign tick_acc = !clr && !load_acc && tick;
    assign at_top   = (count == CNT_MAX);
    assign at_zero  = (count == '0);
    assign wrap     = tick_acc && (dir ? at_zero : at_top);

    // Next binary count for an accepted tick, wrapping inside 0..MODULUS-1.
    always_comb begin
        count_nxt = count;
        if (dir) count_nxt = at_zero ? CNT_MAX : count - WIDTH'(1);
        else     count_nxt = at_top  ? '0      : count + WIDTH'(1);
    end

    // Incremental BCD update with digit ripple; wraps use fixed end values.
    always_comb begin
        logic       ripple;
        logic [4:0] digit_res;
        bcd_step  = count_bcd;
        ripple    = 1'b1;
        digit_res = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (ripple) begin
                digit_res = dir ? bcd_digit_dec(count_bcd[4*i +: 4])
                                : bcd_digit_inc(count_bcd[4*i +: 4]);
                bcd_step[4*i +: 4] = digit_res[3:0];
                ripple = digit_res[4];
            end
        end
        if (at_top && !dir) bcd_step = '0;
        if (at_zero && dir) bcd_step = BCD_MAX;
    end

    // The converter is idle only on the first CONV cycle, which is where the snapshot happens.
    assign conv_start = (state == CONV) && !conv_busy;
    assign conv_abort = clr || load_acc;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (conv_start),
        .abort  (conv_abort),
        .din    (count),
        .busy   (conv_busy),
        .done   (conv_done),
        .result (conv_result)
    );

    // A tick landing in DONE would make the result stale, so it counts as dirty right away.
    assign write_bcd = (state == DONE) && !dirty && !tick_acc && !clr && !load_acc;

    // Converter sequencing: loads (re)start it, clr cancels it, stale results are redone.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_acc) state_nxt = CONV;
            CONV:    if (conv_done) state_nxt = DONE;
            DONE:    state_nxt = (dirty || tick_acc) ? CONV : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (load_acc) state_nxt = CONV;
        if (clr)      state_nxt = IDLE;
    end

    // Count, BCD shadow, strobes and converter bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            dirty     <= 1'b0;
            count     <= '0;
            count_bcd <= '0;
            bcd_valid <= 1'b1;
            carry     <= 1'b0;
            lap_val   <= '0;
            load_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            carry    <= wrap;
            load_err <= load && !load_ok && !clr;
            if (lap) lap_val <= count;

            if (clr)                              dirty <= 1'b0;
            else if (tick_acc && state != IDLE)   dirty <= 1'b1;
            else if (conv_start)                  dirty <= 1'b0;

            if (clr) begin
                count     <= '0;
                count_bcd <= '0;
                bcd_valid <= 1'b1;
            end else if (load_acc) begin
                count     <= load_val;
                bcd_valid <= 1'b0;
            end else begin
                if (tick_acc) begin
                    count <= count_nxt;
                    if (state == IDLE) count_bcd <= bcd_step;
                end
                if (write_bcd) begin
                    count_bcd <= conv_result;
                    bcd_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_modn_counter.sv
// Bench for modn_counter (WIDTH=6, MODULUS=60, DIGITS=2): directed scenarios plus a random run
// against an arithmetic reference model of count, carry, lap and load_err.
module tb_modn_counter;

    localparam int W = 6;
    localparam int M = 60;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tick = 1'b0;
    logic         dir = 1'b0;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         lap = 1'b0;
    logic [W-1:0] count;
    logic [4*D-1:0] count_bcd;
    logic         bcd_valid;
    logic         carry;
    logic [W-1:0] lap_val;
    logic         load_err;

    int n_cmp = 0;
    int n_bad = 0;

    int   m_count = 0;
    int   m_lap = 0;
    logic m_carry = 1'b0;
    logic m_lerr = 1'b0;
    logic m_vknown = 1'b0;
    logic m_vexp = 1'b1;

    modn_counter #(.WIDTH(W), .MODULUS(M), .DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .dir       (dir),
        .clr       (clr),
        .load      (load),
        .load_val  (load_val),
        .lap       (lap),
        .count     (count),
        .count_bcd (count_bcd),
        .bcd_valid (bcd_valid),
        .carry     (carry),
        .lap_val   (lap_val),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    // Reference behaviour for the edge about to happen, from the current inputs.
    task automatic model_edge();
        m_carry  = 1'b0;
        m_lerr   = 1'b0;
        m_vknown = 1'b0;
        if (!rst_n) begin
            m_count = 0; m_lap = 0; m_vknown = 1'b1; m_vexp = 1'b1;
            return;
        end
        if (lap) m_lap = m_count;
        if (clr) begin
            m_count = 0; m_vknown = 1'b1; m_vexp = 1'b1;
        end else if (load && int'(load_val) < M) begin
            m_count = int'(load_val); m_vknown = 1'b1; m_vexp = 1'b0;
        end else begin
            if (load) m_lerr = 1'b1;
            if (tick) begin
                m_count = dir ? m_count - 1 : m_count + 1;
                if (m_count == M) begin m_count = 0;     m_carry = 1'b1; end
                if (m_count < 0)  begin m_count = M - 1; m_carry = 1'b1; end
            end
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = W'(v);
        cyc();
        load = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bcd_valid && n < 40) begin
            n++;
            cyc();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(); cyc();
        n_cmp++; if (count !== 6'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (count_bcd !== 8'h00) begin n_bad++; $display("FAIL reset_bcd: got %h want 00", count_bcd); end
        n_cmp++; if (bcd_valid !== 1'b1) begin n_bad++; $display("FAIL reset_valid: got %b want 1", bcd_valid); end
        n_cmp++; if ({carry, load_err} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got %b want 00", {carry, load_err}); end
        n_cmp++; if (lap_val !== 6'd0) begin n_bad++; $display("FAIL reset_lap: got %0d want 0", lap_val); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_up_wrap();
        int n;
        dir = 1'b0;
        do_load(58);
        wait_valid(n);
        n_cmp++; if (bcd_valid !== 1'b1) begin n_bad++; $display("FAIL upwrap_wait: valid %b after %0d cycles, want 1", bcd_valid, n); end
        n_cmp++; if (count_bcd !== 8'h58) begin n_bad++; $display("FAIL upwrap_bcd58: got %h want 58", count_bcd); end
        tick = 1'b1;
        cyc();
        n_cmp++; if (count !== 6'd59 || carry !== 1'b0) begin n_bad++; $display("FAIL upwrap_first: count %0d carry %b, want 59 0", count, carry); end
        n_cmp++; if (count_bcd !== 8'h59) begin n_bad++; $display("FAIL upwrap_bcd59: got %h want 59", count_bcd); end
        cyc();
        tick = 1'b0;
        n_cmp++; if (count !== 6'd0 || carry !== 1'b1) begin n_bad++; $display("FAIL upwrap_wrap: count %0d carry %b, want 0 1", count, carry); end
        n_cmp++; if (count_bcd !== 8'h00) begin n_bad++; $display("FAIL upwrap_bcd00: got %h want 00", count_bcd); end
        cyc();
        n_cmp++; if (carry !== 1'b0) begin n_bad++; $display("FAIL upwrap_carry_len: got %b want 0", carry); end
    endtask

    task automatic test_down_wrap();
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        dir = 1'b1; tick = 1'b1;
        cyc();
        n_cmp++; if (count !== 6'd59 || carry !== 1'b1) begin n_bad++; $display("FAIL downwrap_wrap: count %0d carry %b, want 59 1", count, carry); end
        n_cmp++; if (count_bcd !== 8'h59) begin n_bad++; $display("FAIL downwrap_bcd59: got %h want 59", count_bcd); end
        cyc();
        tick = 1'b0; dir = 1'b0;
        n_cmp++; if (count !== 6'd58 || carry !== 1'b0) begin n_bad++; $display("FAIL downwrap_next: count %0d carry %b, want 58 0", count, carry); end
        n_cmp++; if (count_bcd !== 8'h58) begin n_bad++; $display("FAIL downwrap_bcd58: got %h want 58", count_bcd); end
    endtask

    task automatic test_load_conv();
        int n;
        do_load(37);
        n_cmp++; if (count !== 6'd37) begin n_bad++; $display("FAIL load_count: got %0d want 37", count); end
        wait_valid(n);
        n_cmp++; if (n != W + 2) begin n_bad++; $display("FAIL load_latency: valid low %0d cycles, want %0d", n, W + 2); end
        n_cmp++; if (count_bcd !== 8'h37) begin n_bad++; $display("FAIL load_bcd: got %h want 37", count_bcd); end
    endtask

    task automatic test_dirty_reconv();
        int n;
        do_load(37);
        cyc(); cyc();
        tick = 1'b1; dir = 1'b0;
        cyc();
        tick = 1'b0;
        n_cmp++; if (count !== 6'd38) begin n_bad++; $display("FAIL dirty_count: got %0d want 38", count); end
        wait_valid(n);
        n_cmp++; if (n <= W + 2 - 3 || bcd_valid !== 1'b1) begin n_bad++; $display("FAIL dirty_relatency: valid %b after %0d more cycles, want 1 after more than %0d", bcd_valid, n, W - 1); end
        n_cmp++; if (count_bcd !== 8'h38) begin n_bad++; $display("FAIL dirty_bcd: got %h want 38", count_bcd); end
    endtask

    task automatic test_priority();
        int n;
        do_load(12);
        wait_valid(n);
        clr = 1'b1; load = 1'b1; load_val = 6'd20; tick = 1'b1;
        cyc();
        clr = 1'b0; load = 1'b0;
        n_cmp++; if (count !== 6'd0 || count_bcd !== 8'h00) begin n_bad++; $display("FAIL prio_clr: count %0d bcd %h, want 0 00", count, count_bcd); end
        n_cmp++; if (bcd_valid !== 1'b1 || carry !== 1'b0) begin n_bad++; $display("FAIL prio_flags: valid %b carry %b, want 1 0", bcd_valid, carry); end
        // 75 does not fit in 6 bits; 63 is the representable out-of-range value.
        load = 1'b1; load_val = 6'd63;
        cyc();
        load = 1'b0; tick = 1'b0;
        n_cmp++; if (count !== 6'd1 || load_err !== 1'b1) begin n_bad++; $display("FAIL prio_badload: count %0d err %b, want 1 1", count, load_err); end
        cyc();
        n_cmp++; if (load_err !== 1'b0 || count_bcd !== 8'h01 || bcd_valid !== 1'b1) begin n_bad++; $display("FAIL prio_after: err %b bcd %h valid %b, want 0 01 1", load_err, count_bcd, bcd_valid); end
    endtask

    task automatic test_lap_reset();
        int n;
        do_load(20);
        wait_valid(n);
        lap = 1'b1; tick = 1'b1; dir = 1'b0;
        cyc();
        lap = 1'b0; tick = 1'b0;
        n_cmp++; if (lap_val !== 6'd20 || count !== 6'd21) begin n_bad++; $display("FAIL lap_capture: lap %0d count %0d, want 20 21", lap_val, count); end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        n_cmp++; if (lap_val !== 6'd20 || count !== 6'd0) begin n_bad++; $display("FAIL lap_clr: lap %0d count %0d, want 20 0", lap_val, count); end
        do_load(45);
        cyc(); cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        n_cmp++; if (count !== 6'd0 || lap_val !== 6'd0 || count_bcd !== 8'h00) begin n_bad++; $display("FAIL midconv_reset: count %0d lap %0d bcd %h, want 0 0 00", count, lap_val, count_bcd); end
        n_cmp++; if (bcd_valid !== 1'b1 || carry !== 1'b0 || load_err !== 1'b0) begin n_bad++; $display("FAIL midconv_flags: valid %b carry %b err %b, want 1 0 0", bcd_valid, carry, load_err); end
        for (int i = 0; i < 12; i++) begin
            cyc();
            n_cmp++; if (bcd_valid !== 1'b1 || count_bcd !== 8'h00) begin n_bad++; $display("FAIL midconv_stale: cycle %0d valid %b bcd %h, want 1 00", i, bcd_valid, count_bcd); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick     = ($urandom_range(0, 1) == 1);
            dir      = ($urandom_range(0, 1) == 1);
            clr      = ($urandom_range(0, 99) < 3);
            load     = ($urandom_range(0, 99) < 6);
            load_val = W'($urandom_range(0, 63));
            lap      = ($urandom_range(0, 9) == 0);
            cyc();
            n_cmp++; if (count !== W'(m_count) || carry !== m_carry) begin n_bad++; $display("FAIL rand_count: cycle %0d count %0d carry %b, want %0d %b", i, count, carry, m_count, m_carry); end
            n_cmp++; if (lap_val !== W'(m_lap) || load_err !== m_lerr) begin n_bad++; $display("FAIL rand_lap_err: cycle %0d lap %0d err %b, want %0d %b", i, lap_val, load_err, m_lap, m_lerr); end
            if (bcd_valid) begin
                n_cmp++; if (count_bcd !== to_bcd(m_count)) begin n_bad++; $display("FAIL rand_bcd: cycle %0d bcd %h, want %h", i, count_bcd, to_bcd(m_count)); end
            end
            if (m_vknown) begin
                n_cmp++; if (bcd_valid !== m_vexp) begin n_bad++; $display("FAIL rand_valid: cycle %0d valid %b, want %b", i, bcd_valid, m_vexp); end
            end
        end
        tick = 1'b0; clr = 1'b0; load = 1'b0; lap = 1'b0;
        for (int i = 0; i < 40; i++) cyc();
        n_cmp++; if (bcd_valid !== 1'b1 || count_bcd !== to_bcd(m_count)) begin n_bad++; $display("FAIL rand_settle: valid %b bcd %h, want 1 %h", bcd_valid, count_bcd, to_bcd(m_count)); end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_conv();
        test_dirty_reconv();
        test_priority();
        test_lap_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/modn_counter.md
Name: modn_counter

Overview:
- Parametrised modulo-N time-digit counter, the general successor to the fixed 0..99 minutes counter.
- Counts up or down on a qualified `tick` and emits a one-cycle carry/borrow for cascading (seconds -> minutes -> hours).
- Supports synchronous clear, synchronous load and lap capture.
- Maintains a packed-BCD shadow of the count for display, kept consistent by incremental update plus a sequential binary-to-BCD converter after loads.

Parameters:
- WIDTH, 7: binary count width; requires 2^WIDTH >= MODULUS.
- MODULUS, 100: count range 0..MODULUS-1; must be >= 2.
- DIGITS, 2: BCD digits on `count_bcd`; requires 10^DIGITS >= MODULUS.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- tick  in  1  count-enable strobe, one cycle per count.
- dir  in  1  0 = up, 1 = down; sampled with `tick`.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- lap  in  1  lap capture strobe.
- count  out  WIDTH  binary count.
- count_bcd  out  4*DIGITS  packed BCD of count, LS digit in [3:0].
- bcd_valid  out  1  `count_bcd` equals `count`.
- carry  out  1  one-cycle pulse on up-wrap or down-wrap (borrow).
- lap_val  out  WIDTH  count captured at last lap.
- load_err  out  1  one-cycle pulse: load rejected.

Behaviour:
- Reset (rst_n low at clk edge): all outputs 0 except `bcd_valid` = 1; FSM to IDLE; any conversion aborted.
- Per-cycle priority: clr > load > tick.
- clr: count <= 0, count_bcd <= 0, bcd_valid <= 1, FSM -> IDLE, carry 0. A simultaneous tick or load is discarded.
- load with load_val < MODULUS: count <= load_val next edge; tick that cycle is discarded; bcd_valid <= 0; conversion starts.
- load with load_val >= MODULUS: count unchanged; load_err = 1 next cycle; tick that cycle still processed.
- tick, up: count == MODULUS-1 -> 0 with carry = 1 for that one cycle; else count + 1.
- tick, down: count == 0 -> MODULUS-1 with carry = 1; else count - 1.
- carry is registered; high exactly the cycle after the wrapping edge.
- Arithmetic is modulo MODULUS only; no intermediate result may exceed WIDTH bits.
- IDLE state: count_bcd updated on each tick in the same edge as count, using BCD digit increment/decrement with ripple. Up-wrap to all-zero; down-wrap to BCD(MODULUS-1), a constant.
- Converter FSM states: IDLE, CONV, DONE.
- IDLE -> CONV: on accepted load.
- CONV entry: snapshot the post-load count into a shift register; clear the dirty flag.
- CONV: WIDTH cycles of shift-add-3 (double dabble).
- CONV -> DONE: after WIDTH shifts.
- DONE, dirty clear: count_bcd <= result, bcd_valid <= 1, -> IDLE.
- DONE, dirty set: re-snapshot count, -> CONV.
- Dirty flag: set by any tick processed while not in IDLE.
- Latency with no interfering tick: bcd_valid low for exactly WIDTH+2 cycles after the load edge.
- A new valid load during CONV/DONE restarts the conversion from the new value.
- lap: lap_val <= count as seen before that edge's tick, load or clr; lap_val is unaffected by clr.
- Reset asserted mid-conversion: state identical to post-reset; no stale BCD ever written.

Decomposition:
- Shared package modn_counter_pkg:
  - function bcd_of_const(int) for elaborating BCD(MODULUS-1);
  - BCD digit inc/dec functions;
  - conversion state enum (IDLE, CONV, DONE).
- One sub-module: bin2bcd_seq, a start/busy/done sequential double-dabble with a WIDTH/DIGITS parameter; owns the shift register and cycle counter.
- Elaboration-time assertions on all parameter constraints.

Test Plan (WIDTH=6, MODULUS=60, DIGITS=2):
- Up-wrap: load 58, wait bcd_valid, tick x2 -> count 59 then 0; carry high only the cycle after the second edge; count_bcd 0x59 then 0x00.
- Down-wrap: after reset, dir=1, tick -> count 59, count_bcd 0x59, carry pulse; tick again -> 58, no carry.
- Load conversion: load 37 -> count 37 next edge; bcd_valid low exactly 8 cycles, then count_bcd 0x37.
- Dirty reconversion: load 37; tick (up) 3 cycles later -> count 38; bcd_valid stays low through the re-conversion, then count_bcd 0x38.
- Priority: clr+load+tick same cycle from count 12 -> count 0, count_bcd 0x00, bcd_valid 1, no carry. Then load 75 with tick -> count 1, load_err pulse, count unchanged apart from the tick.
- Lap and reset: at count 20, lap+tick -> lap_val 20, count 21. rst_n low mid-CONV -> all outputs 0, bcd_valid 1, lap_val 0.
